// File: rtl/qracc_pkg.sv
// Shared types and defaults for the QRAcc activation path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// act_vec_t is the vector type at the default geometry. seq_acc uses it as
// its mac_data_i type, so both ends of the link agree on the element layout.
package qracc_pkg;

    localparam int QRACC_INPUT_BITS     = 4;
    localparam int QRACC_INPUT_ELEMENTS = 128;
    localparam int QRACC_BUS_BITS       = 32;
    localparam int QRACC_COUNT_BITS     = 8;

    // Element i occupies bits [i*inputBits +: inputBits].
    typedef logic [QRACC_INPUT_ELEMENTS-1:0][QRACC_INPUT_BITS-1:0] act_vec_t;

    // Number of bus beats that make up one full vector.
    function automatic int beats_per_vector(input int elems, input int bits, input int bus);
        return elems / (bus / bits);
    endfunction

endpackage

// File: rtl/qracc_vec_packer.sv
// Packs bus beats into one activation vector and zero-pads early-terminated vectors.
// Latency: comb done_o/vec_o on the completing beat; fill state updates on the same edge.
// Backpressure: none internally; the parent gates beat_en_i with its ready.
//
// Ports:
//   clk, nrst    clock, synchronous active-low reset
//   in_data_i    upstream beat; lane j = in_data_i[j*inputBits +: inputBits]
//   in_last_i    beat closes the vector early (qualified by beat_en_i)
//   beat_en_i    beat accepted this cycle
//   vec_o        fully assembled vector including the current beat (valid with done_o)
//   done_o       one-cycle strobe: the accepted beat completes a vector
module qracc_vec_packer
    import qracc_pkg::*;
#(
    parameter int inputBits     = QRACC_INPUT_BITS,
    parameter int inputElements = QRACC_INPUT_ELEMENTS,
    parameter int busBits       = QRACC_BUS_BITS
) (
    input  logic                                     clk,
    input  logic                                     nrst,
    input  logic [busBits-1:0]                       in_data_i,
    input  logic                                     in_last_i,
    input  logic                                     beat_en_i,
    output logic [inputElements-1:0][inputBits-1:0]  vec_o,
    output logic                                     done_o
);

    localparam int LANES = busBits / inputBits;
    localparam int BEATS = beats_per_vector(inputElements, inputBits, busBits);
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef logic [inputElements-1:0][inputBits-1:0] vec_t;

    logic [BW-1:0] beat_q, beat_d;
    vec_t          fill_q, fill_d;
    vec_t          merged;
    logic          last_beat;

    // Current beat dropped into its slot. Slots above the current beat are
    // forced to zero so an early in_last_i yields a zero-padded vector even
    // if the fill register were ever to hold something there.
    always_comb begin
        merged = fill_q;
        for (int b = 0; b < BEATS; b++) begin
            for (int j = 0; j < LANES; j++) begin
                if (BW'(b) == beat_q) begin
                    merged[b*LANES + j] = in_data_i[j*inputBits +: inputBits];
                end else if (BW'(b) > beat_q) begin
                    merged[b*LANES + j] = '0;
                end
            end
        end
    end

    assign last_beat = (beat_q == BW'(BEATS - 1));
    assign done_o    = beat_en_i && (in_last_i || last_beat);
    assign vec_o     = merged;

    // On completion the fill register is cleared so nothing carries over.
    always_comb begin
        beat_d = beat_q;
        fill_d = fill_q;
        if (beat_en_i) begin
            if (done_o) begin
                beat_d = '0;
                fill_d = '0;
            end else begin
                beat_d = beat_q + BW'(1);
                fill_d = merged;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            beat_q <= '0;
            fill_q <= '0;
        end else begin
            beat_q <= beat_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/qracc_act_feeder.sv
// Activation feeder: packs bus beats into vectors and hands them to seq_acc.
// Latency: mac_valid_o rises the cycle after the completing beat is accepted.
// Backpressure: vectors held stable until mac_ready_i; in_ready_o drops when buffers are full.
//
// Ports:
//   clk, nrst                 clock, synchronous active-low reset
//   in_data_i/_valid_i/_last_i/in_ready_o   upstream beat stream
//   mac_data_o/mac_valid_o/mac_ready_i      vector handshake towards seq_acc
//   vec_count_o               vectors transferred since reset (wraps)
//
// Build option QRACC_FEEDER_DBUF_EN: two ping-pong output entries so the next
// vector can fill while the previous one waits on mac_ready_i. Without it a
// single entry is used and filling stalls from completion until transfer.
module qracc_act_feeder
    import qracc_pkg::*;
#(
    parameter int inputBits     = QRACC_INPUT_BITS,
    parameter int inputElements = QRACC_INPUT_ELEMENTS,
    parameter int busBits       = QRACC_BUS_BITS,
    parameter int countBits     = QRACC_COUNT_BITS
) (
    input  logic                                     clk,
    input  logic                                     nrst,
    input  logic [busBits-1:0]                       in_data_i,
    input  logic                                     in_valid_i,
    input  logic                                     in_last_i,
    output logic                                     in_ready_o,
    output logic [inputElements-1:0][inputBits-1:0]  mac_data_o,
    output logic                                     mac_valid_o,
    input  logic                                     mac_ready_i,
    output logic [countBits-1:0]                     vec_count_o
);

    typedef logic [inputElements-1:0][inputBits-1:0] vec_t;

    logic                 beat_acc;
    logic                 xfer;
    logic                 pk_done;
    vec_t                 pk_vec;
    logic [1:0]           occ_q, occ_d;
    logic [countBits-1:0] vec_count_q, vec_count_d;

    assign beat_acc = in_valid_i & in_ready_o;
    assign xfer     = mac_valid_o & mac_ready_i;

    qracc_vec_packer #(
        .inputBits     (inputBits),
        .inputElements (inputElements),
        .busBits       (busBits)
    ) u_packer (
        .clk       (clk),
        .nrst      (nrst),
        .in_data_i (in_data_i),
        .in_last_i (in_last_i),
        .beat_en_i (beat_acc),
        .vec_o     (pk_vec),
        .done_o    (pk_done)
    );

    // Occupancy: completion and transfer in the same cycle cancel out.
    always_comb begin
        occ_d = occ_q;
        case ({pk_done, xfer})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
        vec_count_d = xfer ? vec_count_q + countBits'(1) : vec_count_q;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            occ_q       <= '0;
            vec_count_q <= '0;
        end else begin
            occ_q       <= occ_d;
            vec_count_q <= vec_count_d;
        end
    end

    assign mac_valid_o = (occ_q != 2'd0);
    assign vec_count_o = vec_count_q;

`ifdef QRACC_FEEDER_DBUF_EN
    // Two entries used as a ring: the packer writes at wr_ptr, seq_acc reads
    // at rd_ptr. The entry being presented is never the one being written,
    // because a write only happens while occ_q < 2.
    vec_t buf_q [2];
    vec_t buf_d [2];
    logic wr_ptr_q, wr_ptr_d;
    logic rd_ptr_q, rd_ptr_d;

    always_comb begin
        buf_d    = buf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (pk_done) begin
            buf_d[wr_ptr_q] = pk_vec;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (xfer) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            buf_q    <= buf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // nrst term keeps the upstream stalled while reset is held.
    assign in_ready_o = nrst & (occ_q < 2'd2);
    assign mac_data_o = buf_q[rd_ptr_q];
`else
    // Single entry: it can only be written while empty, so it is stable
    // for as long as mac_valid_o is high.
    vec_t buf_q, buf_d;

    always_comb begin
        buf_d = buf_q;
        if (pk_done) begin
            buf_d = pk_vec;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            buf_q <= '0;
        end else begin
            buf_q <= buf_d;
        end
    end

    // Registered occupancy means a transfer frees the entry one cycle later.
    assign in_ready_o = nrst & (occ_q == 2'd0);
    assign mac_data_o = buf_q;
`endif

endmodule

// File: doc/qracc_act_feeder.md
# qracc_act_feeder

Activation packer and transmitter for the bit-serial MAC path. Accepts narrow activation beats from the upstream bus and assembles full `inputElements × inputBits` vectors. Presents each vector to the sequential accumulator over a valid/ready handshake, holding data stable until accepted. Sits between the activation SRAM/DMA stream and `seq_acc`, driving its `mac_data_i`/`mac_valid_i` and consuming its `ready_o`.

## Interface

Parameters:
- `inputBits`, 4, bits per activation element (two's complement)
- `inputElements`, 128, elements per MAC vector
- `busBits`, 32, upstream beat width; `busBits % inputBits == 0` and `inputElements % (busBits/inputBits) == 0` are required
- `countBits`, 8, width of the issued-vector counter

Ports:
- `clk`  in  1  clock
- `nrst`  in  1  reset, synchronous, active-low
- `in_data_i`  in  busBits  activation beat; lane j = `in_data_i[j*inputBits +: inputBits]`
- `in_valid_i`  in  1  beat valid
- `in_last_i`  in  1  final beat of the current vector; qualified by `in_valid_i`
- `in_ready_o`  out  1  beat accepted when `in_valid_i && in_ready_o`
- `mac_data_o`  out  inputElements×inputBits  packed vector to `seq_acc`
- `mac_valid_o`  out  1  vector valid
- `mac_ready_i`  in  1  `seq_acc` ready; vector transferred when `mac_valid_o && mac_ready_i`
- `vec_count_o`  out  countBits  vectors transferred since reset, wraps modulo 2^countBits

## Operation

- Derived constants: `lanesPerBeat = busBits/inputBits` (8); `beatsPerVector = inputElements/lanesPerBeat` (16).
- Beat counter `beat_q` selects the fill position. Beat k, lane j writes element `k*lanesPerBeat + j` of the fill buffer.
- A vector completes on the accepted beat with `beat_q == beatsPerVector-1` or with `in_last_i`, whichever comes first. `beat_q` then returns to 0.
- Early `in_last_i` at beat k: elements from `(k+1)*lanesPerBeat` upward are forced to 0. `seq_acc` treats 0 elements as bipolar 0.
- `in_last_i` on beat 15 is identical to no `in_last_i`.
- Buffer occupancy `occ_q` counts completed, untransferred vectors.
- Vectors are issued in completion order.
- Fill-buffer state is cleared on vector completion. No stale elements carry into the next vector.
- `vec_count_o` increments on each transferred vector and wraps from 255 to 0.

## Timing

- Reset values: `in_ready_o`=0 while `nrst` low, then 1; `mac_valid_o`=0; `mac_data_o`=0; `vec_count_o`=0; `beat_q`=0; `occ_q`=0.
- Latency: `mac_valid_o` rises on the cycle after the completing beat is accepted.
- `mac_valid_o` and `mac_data_o` are registered. Once `mac_valid_o` rises, both are stable until the transfer cycle. `mac_valid_o` never falls without a transfer.
- `in_ready_o` is combinational from `occ_q` only and never depends on `in_valid_i`.
- Completion and transfer in the same cycle: `occ_q` is unchanged. The next vector is presented on the following cycle with no bubble.
- Reset mid-fill: partial vector discarded; the next accepted beat is beat 0.
- Reset with a vector pending: the vector is dropped and `vec_count_o` is not incremented.
- `in_valid_i` low mid-vector: fill state holds indefinitely. There is no timeout.

## Configuration

- `QRACC_FEEDER_DBUF_EN` defined: two ping-pong buffers, `occ_q` in 0..2.
  - `in_ready_o = (occ_q < 2)`.
  - The next vector fills while the previous vector waits on `mac_ready_i`.
- `QRACC_FEEDER_DBUF_EN` undefined: single buffer, `occ_q` in 0..1.
  - `in_ready_o = (occ_q == 0)`.
  - The fill stalls from completion until transfer.
  - A transfer cycle still raises `in_ready_o` on the next cycle, not the same cycle.

## Structure

- `qracc_pkg` holds:
  - `localparam` defaults for `busBits` and `countBits`
  - typedef `act_vec_t` (`logic [inputElements-1:0][inputBits-1:0]`), shared with `seq_acc`
- One sub-module, `qracc_vec_packer`. It holds one vector register plus its `beat_q`, lane write, and zero-pad logic, and outputs a one-cycle `done` strobe.
- The top level instantiates one packer and holds 1 or 2 output buffer entries, the pointers, `occ_q` and `vec_count_o`.

## Test plan

- Single vector: 16 beats with beat k = `{8{4'(k)}}`, `mac_ready_i`=1.
  - `mac_valid_o` rises the cycle after beat 15.
  - Elements 8k..8k+7 = k.
  - `vec_count_o` = 1 after transfer.
- Backpressure: `mac_ready_i`=0, stream 3 vectors.
  - With DBUF: `in_ready_o` falls after the second completes; with no DBUF: it falls after the first.
  - Release `mac_ready_i` to 1: vectors arrive in order with unchanged data.
- Early last: `in_last_i` on beat 2 with all lanes 4'hF.
  - Elements 0..23 = -1; elements 24..127 = 0.
  - The next vector starts at element 0.
- Mid-fill reset: assert `nrst`=0 for 1 cycle after beat 7, then send 16 fresh beats.
  - Output vector contains only the fresh data.
  - `vec_count_o` = 1.
- Simultaneous events (DBUF): vector A pending and B's last beat accepted on the same cycle as A's transfer.
  - B is valid on the next cycle.
  - `in_ready_o` stays 1 throughout.
- Counter wrap: 256 back-to-back vectors with `in_last_i` on beat 0 each. `vec_count_o` returns to 0.
